// File: rtl/demux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : demux_pkg
//  Description : Shared constants and types for the demux lane buffers.
//                Defaults here size each lane FIFO to match the 1:2 demux
//                lane width and expected burst length.
//  Revision    : 1.0 - initial release
// ============================================================================
package demux_pkg;

    // Demux lane word width; default FIFO data width.
    localparam int LANE_W          = 4;

    // Lane FIFO geometry (DEPTH must be a power of two, at least 4).
    localparam int LANE_FIFO_DEPTH = 8;
    localparam int LANE_FIFO_AF_TH = 6;
    localparam int LANE_FIFO_AE_TH = 2;

    // Pointer width for the default depth; count needs one extra bit so it
    // can represent DEPTH itself.
    localparam int LANE_FIFO_PTR_W = $clog2(LANE_FIFO_DEPTH);
    localparam int LANE_FIFO_CNT_W = LANE_FIFO_PTR_W + 1;

    // Per-edge operation class, formed as {push_accepted, pop_accepted}.
    typedef enum logic [1:0] {
        FIFO_OP_IDLE = 2'b00,
        FIFO_OP_POP  = 2'b01,
        FIFO_OP_PUSH = 2'b10,
        FIFO_OP_BOTH = 2'b11
    } fifo_op_e;

endpackage : demux_pkg
`default_nettype wire

// File: rtl/lane_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : lane_fifo_mem
//  Description : DEPTH x DATA_W register array for one lane FIFO.
//                One synchronous write port, one asynchronous read port.
//                Contents are not reset; occupancy tracking lives in the
//                parent, so stale entries are never observed.
//  Ports       : clk        - clock
//                i_wr_en    - write strobe (already qualified by parent)
//                i_wr_addr  - write index
//                i_wr_data  - write word
//                i_rd_addr  - read index
//                o_rd_data  - word at i_rd_addr (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module lane_fifo_mem #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [PTR_W-1:0]  i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [PTR_W-1:0]  i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : lane_fifo_mem
`default_nettype wire

// File: rtl/demux_lane_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : demux_lane_fifo
//  Description : Per-lane receive buffer behind the 1:2 demux. Circular
//                buffer with registered pop output, occupancy count,
//                threshold flags and a sticky overflow/underflow error.
//  Ports       : clk          - clock, all state on rising edge
//                reset        - synchronous active-high reset
//                wr_en        - push request (demux lane valid)
//                data_in      - push data (demux lane data)
//                rd_en        - pop request from consumer
//                data_out     - popped word, registered
//                valid_out    - data_out was popped on the previous edge
//                full/empty   - count == DEPTH / count == 0
//                almost_full  - count >= AF_TH
//                almost_empty - count <= AE_TH
//                count        - occupancy 0..DEPTH
//                fifo_error   - sticky overflow/underflow, cleared by reset
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_lane_fifo
    import demux_pkg::*;
#(
    parameter int DATA_W = LANE_W,
    parameter int DEPTH  = LANE_FIFO_DEPTH,
    parameter int AF_TH  = LANE_FIFO_AF_TH,
    parameter int AE_TH  = LANE_FIFO_AE_TH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     valid_out,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     fifo_error
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_CNT_AF   = CNT_W'(AF_TH);
    localparam logic [CNT_W-1:0] C_CNT_AE   = CNT_W'(AE_TH);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE  = PTR_W'(1);

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid_out;
    logic              r_fifo_error;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_overflow;
    logic              w_underflow;
    logic [DATA_W-1:0] w_rd_data;
    fifo_op_e          w_op;

    // Flags decode the registered count directly so they track it with no lag.
    assign w_full       = (r_count == C_CNT_FULL);
    assign w_empty      = (r_count == '0);

    // A pop frees a slot on the same edge, so a push into a full FIFO is
    // accepted when a pop is also accepted. Pops never fall through an
    // empty FIFO, even if a push arrives on the same edge.
    assign w_pop        = rd_en && !w_empty;
    assign w_push       = wr_en && (!w_full || w_pop);

    assign w_overflow   = wr_en && w_full && !w_pop;
    assign w_underflow  = rd_en && w_empty;

    assign w_op         = fifo_op_e'({w_push, w_pop});

    lane_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (data_in),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_data_out   <= '0;
            r_valid_out  <= 1'b0;
            r_fifo_error <= 1'b0;
        end else begin
            case (w_op)
                FIFO_OP_PUSH: r_count <= r_count + C_CNT_ONE;
                FIFO_OP_POP:  r_count <= r_count - C_CNT_ONE;
                default:      r_count <= r_count;
            endcase

            // Pointers are exactly PTR_W bits, so they wrap DEPTH-1 -> 0.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end

            // data_out holds its last value on edges without a pop.
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + C_PTR_ONE;
                r_data_out <= w_rd_data;
            end
            r_valid_out <= w_pop;

            if (w_overflow || w_underflow) begin
                r_fifo_error <= 1'b1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign valid_out    = r_valid_out;
    assign count        = r_count;
    assign fifo_error   = r_fifo_error;
    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= C_CNT_AF);
    assign almost_empty = (r_count <= C_CNT_AE);

endmodule : demux_lane_fifo
`default_nettype wire

// File: tb/tb_demux_lane_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_lane_fifo
//  Description : Self-checking bench for demux_lane_fifo. A queue-based
//                reference model predicts each edge; popped words go to a
//                scoreboard queue that an independent monitor drains
//                whenever valid_out is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_lane_fifo;

    localparam int DW    = 4;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [DW-1:0] data_in;
    logic          rd_en;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [3:0]    count;
    logic          fifo_error;

    demux_lane_fifo #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .AF_TH  (AF),
        .AE_TH  (AE)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .fifo_error   (fifo_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: contents as a plain queue, sticky error, last popped.
    logic [DW-1:0] mq[$];
    logic          m_err;
    logic [DW-1:0] m_last;

    // Scoreboard of words expected on data_out, in order.
    logic [DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    task automatic chk_state(input string tag);
        int n;
        n = mq.size();
        chk({tag, ":count"},        32'(count),        32'(n));
        chk({tag, ":full"},         32'(full),         32'(n == DEPTH));
        chk({tag, ":empty"},        32'(empty),        32'(n == 0));
        chk({tag, ":almost_full"},  32'(almost_full),  32'(n >= AF));
        chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ":fifo_error"},   32'(fifo_error),   32'(m_err));
        chk({tag, ":data_out"},     32'(data_out),     32'(m_last));
    endtask

    // One clock edge of normal operation; called with clk low.
    task automatic cycle(input logic w, input logic [DW-1:0] d, input logic r, input string tag);
        logic pop_ok, push_ok;
        wr_en   = w;
        data_in = d;
        rd_en   = r;
        pop_ok  = r && (mq.size() > 0);
        push_ok = w && ((mq.size() < DEPTH) || pop_ok);
        if (r && mq.size() == 0) m_err = 1'b1;
        if (w && mq.size() == DEPTH && !pop_ok) m_err = 1'b1;
        if (pop_ok) begin
            m_last = mq.pop_front();
            exp_q.push_back(m_last);
        end
        if (push_ok) mq.push_back(d);
        @(posedge clk);
        #1;
        chk_state(tag);
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic do_reset(input int n, input logic w, input logic r);
        reset   = 1'b1;
        wr_en   = w;
        rd_en   = r;
        data_in = DW'($urandom_range(0, 15));
        mq.delete();
        m_err   = 1'b0;
        m_last  = '0;
        repeat (n) @(posedge clk);
        #1;
        chk_state("reset");
        chk("reset:valid_out", 32'(valid_out), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Monitor: drains the scoreboard whenever the DUT presents a word.
    always begin
        @(posedge clk);
        #2;
        if (valid_out) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 32'(valid_out), 32'(0));
            else                   chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        m_err   = 1'b0;
        m_last  = '0;
        @(negedge clk);

        // Reset then idle.
        do_reset(2, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, "idle");

        // Fill 0x1..0x8, then drain in order.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, "fill");
        for (int i = 0; i < DEPTH; i++)  cycle(1'b0, '0, 1'b1, "drain");

        // Wrap-around: push 5, pop 5, then 0xA..0xF, then pop all.
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(i + 2), 1'b0, "wrap_push");
        for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1, "wrap_pop");
        for (int i = 10; i <= 15; i++) cycle(1'b1, DW'(i), 1'b0, "wrap_fill");
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, "wrap_drain");

        // Overflow: fill, push 0xC with no pop, then drain.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, "ovf_fill");
        cycle(1'b1, 4'hC, 1'b0, "overflow");
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "ovf_drain");

        // Simultaneous push/pop when full and when empty.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i + 4), 1'b0, "sim_fill");
        cycle(1'b1, 4'h3, 1'b1, "full_both");
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "sim_drain");
        cycle(1'b1, 4'h9, 1'b1, "empty_both");
        chk("empty_both:valid_out", 32'(valid_out), 32'(0));
        cycle(1'b0, '0, 1'b1, "empty_both_pop");

        // Reset mid-operation with a push pending.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, DW'(i + 1), 1'b0, "mid_fill");
        do_reset(1, 1'b1, 1'b0);
        cycle(1'b1, 4'h7, 1'b0, "post_reset_push");
        cycle(1'b0, '0, 1'b1, "post_reset_pop");
        cycle(1'b0, '0, 1'b1, "post_reset_extra");

        // Randomized traffic with write-heavy / read-heavy phases.
        do_reset(1, 1'b0, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            int wp;
            wp = ((i / 64) % 2 == 0) ? 75 : 30;
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'($urandom_range(0, 99) < wp),
                      DW'($urandom_range(0, 15)),
                      1'($urandom_range(0, 99) >= wp - 5),
                      "random");
            end
        end

        repeat (3) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_demux_lane_fifo
`default_nettype wire

// File: doc/demux_lane_fifo.md
# demux_lane_fifo

Per-lane receive buffer placed directly downstream of the 1:2 demux; one instance per demux output (lane 0 fed by `dataout0`/`valid_0`, lane 1 by `dataout1`/`valid_1`). It absorbs the demux's one-word-per-cycle bursts and exposes a pop interface with a registered output for the consuming stage. It also reports occupancy and threshold flags for back-pressure, plus a sticky error for overflow or underflow.

## Interface
- `DATA_W`, 4, word width; matches demux lane width.
- `DEPTH`, 8, number of entries; power of two, minimum 4.
- `AF_TH`, 6, almost-full threshold; `almost_full` = count ≥ AF_TH.
- `AE_TH`, 2, almost-empty threshold; `almost_empty` = count ≤ AE_TH.
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push request; connected to the demux lane valid.
- `data_in`  in  DATA_W  push data; connected to the demux lane data.
- `rd_en`  in  1  pop request from the consumer.
- `data_out`  out  DATA_W  popped word, registered.
- `valid_out`  out  1  `data_out` holds a word popped on the previous edge.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_TH.
- `almost_empty`  out  1  count ≤ AE_TH.
- `count`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `fifo_error`  out  1  sticky overflow/underflow indicator.

## Operation
- Storage: circular buffer with `wr_ptr`, `rd_ptr`, each log2(DEPTH) bits, wrapping naturally from DEPTH-1 to 0. Occupancy is tracked in `count`.
- Push accepted when `wr_en` && (!full || pop accepted this cycle). The word is written at `wr_ptr`, then `wr_ptr` increments.
- Pop accepted when `rd_en` && !empty. The word at `rd_ptr` is registered into `data_out`, `valid_out`=1 on the next edge, and `rd_ptr` increments.
- No pop accepted on an edge: `valid_out`=0 on that edge and `data_out` holds its last value.
- `count` update per edge: +1 push only, −1 pop only, unchanged for both or neither.
- Full with `wr_en` and `rd_en` both high: both accepted; count stays DEPTH.
- Empty with `wr_en` and `rd_en` both high: push accepted, pop rejected (no fall-through); this is an underflow; count becomes 1.
- Overflow: `wr_en` while full and no pop accepted. The word is dropped, pointers and count are unchanged, and `fifo_error` is set.
- Underflow: `rd_en` while empty. No pointer change, `valid_out`=0, and `fifo_error` is set.
- `fifo_error` clears only on reset.
- Flags `full`, `empty`, `almost_full`, `almost_empty` are combinational decodes of the registered `count`; they have no extra cycle of lag.

## Timing
- Reset values, applied on a `clk` edge with `reset`=1: pointers 0, count 0, `data_out`=0, `valid_out`=0, `fifo_error`=0. Resulting flags: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0.
- Reset overrides `wr_en` and `rd_en` on the same edge. Mid-operation reset discards all contents; the stored memory values are don't-care afterwards.
- Write-to-read latency: a word pushed on edge N can be popped with `rd_en` at N+1 and appears on `data_out` after edge N+1. Minimum latency is 2 edges from push to visible output.
- Throughput: one push and one pop per cycle, sustained indefinitely when 0 < count < DEPTH.

## Structure
- Shared package `demux_pkg`:
  - `LANE_W`=4 (`DATA_W` default).
  - `LANE_FIFO_DEPTH`=8.
  - default AF/AE thresholds.
  - `clog2`-based pointer-width constant.
- Sub-module `lane_fifo_mem`: DEPTH×DATA_W register array with one synchronous write port and one asynchronous read port. Pointer, count, flag, and error logic stay in `demux_lane_fifo`.
- The top level instantiates two `demux_lane_fifo` on the demux outputs.

## Test plan
- Reset then idle: assert `reset` for 2 cycles → `count`=0, `empty`=1, `almost_empty`=1, `valid_out`=0, `fifo_error`=0.
- Fill and drain (`DEPTH`=8): push 0x1..0x8 on consecutive cycles → `full`=1 and `count`=8, with `almost_full` first high at count 6. Then pop 8 times → `data_out` = 0x1..0x8 in order, `valid_out`=1 each cycle, `empty`=1 at the end, `fifo_error`=0.
- Wrap-around: push 5, pop 5, then push 0xA..0xF (6 words) → pointers wrap past index 7. Popping returns 0xA..0xF in order, with count sequence 1..6 and back to 0.
- Overflow: fill to 8, then push 0xC with `rd_en`=0 → `count` stays 8, `fifo_error`=1. Subsequent pops return the original 8 words; 0xC never appears.
- Simultaneous at boundaries:
  - When full, push 0x3 and pop together → count stays 8, the head word is output, and 0x3 becomes the tail.
  - When empty, push and pop together → count becomes 1, `valid_out`=0, `fifo_error`=1.
- Reset mid-operation: with count=5, assert `reset` one cycle while `wr_en`=1 → count 0, `empty`=1, `fifo_error`=0. The next push followed by a pop returns only the new word.
